// File: rtl/adc_moving_avg_pkg.sv
// rtl/adc_moving_avg_pkg.sv - shared constants, state type and mV scaling for the ADC averager
package adc_pkg;

   localparam int ADC_FULL_SCALE_MV = 3300;
   localparam int MV_SCALE_K        = 53009;
   localparam int MV_SCALE_SHIFT    = 12;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } avg_state_t;

   // K/2^SHIFT approximates 3300/255; the result is truncated, never rounded
   function automatic logic [15:0] code_to_mv(input logic [15:0] code);
      logic [31:0] prod;
      prod = 32'(code) * 32'(MV_SCALE_K);
      return 16'(prod >> MV_SCALE_SHIFT);
   endfunction

endpackage

// File: rtl/adc_moving_avg_if.sv
// rtl/adc_moving_avg_if.sv - sample input and averaged output bundle of the ADC averager
interface adc_moving_avg_if #(
   parameter int WIDTH = 8
);

   logic             sample_valid;
   logic [WIDTH-1:0] sample_code;
   logic             avg_valid;
   logic [WIDTH-1:0] avg_code;
   logic [15:0]      avg_mV;
   logic             filled;
   logic [WIDTH-1:0] min_code;
   logic [WIDTH-1:0] max_code;

   modport master (
      output sample_valid,
      output sample_code,
      input  avg_valid,
      input  avg_code,
      input  avg_mV,
      input  filled,
      input  min_code,
      input  max_code
   );

   modport slave (
      input  sample_valid,
      input  sample_code,
      output avg_valid,
      output avg_code,
      output avg_mV,
      output filled,
      output min_code,
      output max_code
   );

endinterface

// File: rtl/adc_moving_avg_ram.sv
// rtl/adc_moving_avg_ram.sv - DEPTH x WIDTH ring buffer, sync write, async read-before-write
module adc_avg_ram #(
   parameter int WIDTH      = 8,
   parameter int LOG2_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [LOG2_DEPTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   localparam int DEPTH = 1 << LOG2_DEPTH;

   // no reset so the array maps onto distributed RAM
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/adc_moving_avg.sv
// rtl/adc_moving_avg.sv - windowed mean of ADC codes with mV output; min/max tracking under `ADC_MINMAX_TRACK_EN
module adc_moving_avg
   import adc_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int LOG2_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   adc_moving_avg_if.slave bus
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = WIDTH + LOG2_DEPTH;
   localparam int CNT_W = LOG2_DEPTH + 1;

   if (LOG2_DEPTH < 1 || LOG2_DEPTH > 8) begin : g_bad_depth
      $error("adc_moving_avg: LOG2_DEPTH must be 1..8");
   end
   if (WIDTH == 8 && code_to_mv(16'd255) != 16'(ADC_FULL_SCALE_MV)) begin : g_bad_scale
      $error("adc_moving_avg: mV scale does not reach full scale");
   end

   avg_state_t            state;
   logic [CNT_W-1:0]      count;
   logic [SUM_W-1:0]      sum;
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [WIDTH-1:0]      oldest;
   logic [WIDTH-1:0]      avg_next;
   logic                  accept;
   logic                  sum_fresh;

   assign accept   = bus.sample_valid && !clear && !reset;
   assign avg_next = sum[SUM_W-1 -: WIDTH];

   adc_avg_ram #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .addr  (wr_ptr),
      .wdata (bus.sample_code),
      .rdata (oldest)
   );

   // sum_fresh marks a sum that was updated while FULL; the average is registered one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= EMPTY;
         count         <= '0;
         sum           <= '0;
         wr_ptr        <= '0;
         sum_fresh     <= 1'b0;
         bus.avg_valid <= 1'b0;
         bus.avg_code  <= '0;
         bus.avg_mV    <= '0;
         bus.filled    <= 1'b0;
      end else if (clear) begin
         state         <= EMPTY;
         count         <= '0;
         sum           <= '0;
         wr_ptr        <= '0;
         sum_fresh     <= 1'b0;
         bus.avg_valid <= 1'b0;
         bus.filled    <= 1'b0;
      end else begin
         bus.avg_valid <= sum_fresh;
         sum_fresh     <= 1'b0;
         if (sum_fresh) begin
            bus.avg_code <= avg_next;
            bus.avg_mV   <= code_to_mv(16'(avg_next));
         end
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (state == FULL) begin
               sum       <= sum + SUM_W'(bus.sample_code) - SUM_W'(oldest);
               sum_fresh <= 1'b1;
            end else begin
               sum   <= sum + SUM_W'(bus.sample_code);
               count <= count + 1'b1;
               if (count == CNT_W'(DEPTH - 1)) begin
                  state      <= FULL;
                  bus.filled <= 1'b1;
                  sum_fresh  <= 1'b1;
               end else begin
                  state <= FILLING;
               end
            end
         end
      end
   end

`ifdef ADC_MINMAX_TRACK_EN
   logic mm_loaded;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         mm_loaded    <= 1'b0;
         bus.min_code <= '0;
         bus.max_code <= '0;
      end else if (accept) begin
         mm_loaded <= 1'b1;
         if (!mm_loaded || bus.sample_code < bus.min_code) begin
            bus.min_code <= bus.sample_code;
         end
         if (!mm_loaded || bus.sample_code > bus.max_code) begin
            bus.max_code <= bus.sample_code;
         end
      end
   end
`else
   assign bus.min_code = '0;
   assign bus.max_code = '0;
`endif

endmodule

// File: tb/tb_adc_moving_avg.sv
// tb/tb_adc_moving_avg.sv - directed self-checking bench for adc_moving_avg at WIDTH=8, DEPTH=16
module tb_adc_moving_avg;

   logic clk = 1'b0;
   logic reset;
   logic clear;

   always #5 clk = ~clk;

   adc_moving_avg_if #(.WIDTH(8)) bus ();

   adc_moving_avg #(
      .WIDTH      (8),
      .LOG2_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   int         n_checks  = 0;
   int         n_fail    = 0;
   int         n_strobes = 0;
   int         base;
   logic [7:0] strobe_q [$];

   always @(negedge clk) begin
      if (bus.avg_valid === 1'b1) begin
         n_strobes++;
         strobe_q.push_back(bus.avg_code);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] code);
      bus.sample_valid = 1'b1;
      bus.sample_code  = code;
      tick();
      bus.sample_valid = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(bus.avg_valid), 0);
      check({tag, "_code"},  32'(bus.avg_code),  0);
      check({tag, "_mv"},    32'(bus.avg_mV),    0);
      check({tag, "_filled"}, 32'(bus.filled),   0);
      check({tag, "_min"},   32'(bus.min_code),  0);
      check({tag, "_max"},   32'(bus.max_code),  0);
   endtask

   initial begin
      reset            = 1'b1;
      clear            = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_code  = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_all_zero("reset");

      // 16 x 128: one strobe, two cycles after the 16th sample
      repeat (15) send(8'd128);
      tick();
      tick();
      check("fill15_strobes", n_strobes, 0);
      check("fill15_filled", 32'(bus.filled), 0);
      send(8'd128);
      check("fill16_filled", 32'(bus.filled), 1);
      check("fill16_n1_valid", 32'(bus.avg_valid), 0);
      tick();
      check("fill16_valid", 32'(bus.avg_valid), 1);
      check("avg128_code", 32'(bus.avg_code), 128);
      check("avg128_mv", 32'(bus.avg_mV), 1656);
      tick();
      check("avg128_valid_drop", 32'(bus.avg_valid), 0);
      check("avg128_one_strobe", n_strobes, 1);

      // full window of 255
      repeat (16) send(8'd255);
      tick();
      check("avg255_code", 32'(bus.avg_code), 255);
      check("avg255_mv", 32'(bus.avg_mV), 3300);
      tick();

      // 16 x 0 back to back
      strobe_q.delete();
      base = n_strobes;
      repeat (16) send(8'd0);
      tick();
      check("avg0_code", 32'(bus.avg_code), 0);
      check("avg0_mv", 32'(bus.avg_mV), 0);
      tick();
      check("ramp_strobes", n_strobes - base, 16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("ramp_step%0d", i), 32'(strobe_q[i]), (255 * (15 - i)) / 16);
      end

      // clear together with a sample while FULL
      base             = n_strobes;
      bus.sample_valid = 1'b1;
      bus.sample_code  = 8'd200;
      clear            = 1'b1;
      tick();
      clear            = 1'b0;
      bus.sample_valid = 1'b0;
      check("clrs_filled", 32'(bus.filled), 0);
      tick();
      tick();
      check("clrs_no_strobe", n_strobes - base, 0);

      // 10 samples, clear, then a fresh window of 64
      repeat (10) send(8'd100);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr10_filled", 32'(bus.filled), 0);
      repeat (15) send(8'd64);
      tick();
      tick();
      check("w64_15_filled", 32'(bus.filled), 0);
      check("w64_15_strobes", n_strobes - base, 0);
      send(8'd64);
      check("w64_filled", 32'(bus.filled), 1);
      tick();
      check("w64_valid", 32'(bus.avg_valid), 1);
      check("w64_code", 32'(bus.avg_code), 64);
      check("w64_mv", 32'(bus.avg_mV), 828);
      tick();

      // clear in N+1 cancels the strobe in flight, outputs hold
      base = n_strobes;
      send(8'd64);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      tick();
      check("cancel_strobes", n_strobes - base, 0);
      check("hold_code", 32'(bus.avg_code), 64);
      check("hold_mv", 32'(bus.avg_mV), 828);
      check("hold_filled", 32'(bus.filled), 0);

      // reset mid-fill behaves like power-up
      repeat (8) send(8'd30);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("midreset");
      base = n_strobes;
      repeat (15) send(8'd30);
      tick();
      tick();
      check("post_reset15_strobes", n_strobes - base, 0);
      check("post_reset15_filled", 32'(bus.filled), 0);
      send(8'd30);
      tick();
      check("post_reset_valid", 32'(bus.avg_valid), 1);
      check("post_reset_code", 32'(bus.avg_code), 30);
      check("post_reset_mv", 32'(bus.avg_mV), 388);
      tick();

      reset = 1'b1;
      tick();
      reset = 1'b0;
      send(8'd50);
      send(8'd10);
      send(8'd240);
      send(8'd90);
`ifdef ADC_MINMAX_TRACK_EN
      check("mm_min", 32'(bus.min_code), 10);
      check("mm_max", 32'(bus.max_code), 240);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("mm_clr_min", 32'(bus.min_code), 0);
      check("mm_clr_max", 32'(bus.max_code), 0);
      send(8'd77);
      check("mm_first_min", 32'(bus.min_code), 77);
      check("mm_first_max", 32'(bus.max_code), 77);
`else
      check("mm_off_min", 32'(bus.min_code), 0);
      check("mm_off_max", 32'(bus.max_code), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
